// File: rtl/cordic_iter_engine.sv
`default_nettype none
// ============================================================================
// Module   : cordic_iter_engine
// Purpose  : Folded CORDIC engine; one saturating micro-rotation per clock,
//            run-time selectable rotation/vectoring and coordinate system.
// Revision : 1.0
// ============================================================================
module cordic_iter_engine #(
    parameter int N_INT          = 0,
    parameter int N_FRAC         = -9,
    parameter int ITERATIONS     = 12,
    parameter int SHIFT_BITWIDTH = 4,
    localparam int BITWIDTH      = N_INT - N_FRAC + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic                      mode_i,
    input  logic [1:0]                coord_i,
    input  logic [BITWIDTH-1:0]       X_i,
    input  logic [BITWIDTH-1:0]       Y_i,
    input  logic [BITWIDTH-1:0]       Z_i,
    output logic [SHIFT_BITWIDTH-1:0] angle_idx_o,
    output logic [1:0]                angle_coord_o,
    input  logic [BITWIDTH-1:0]       angle_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [BITWIDTH-1:0]       X_o,
    output logic [BITWIDTH-1:0]       Y_o,
    output logic [BITWIDTH-1:0]       Z_o,
    output logic                      busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] COORD_CIRC = 2'd0;
    localparam logic [1:0] COORD_LIN  = 2'd1;
    localparam logic [1:0] COORD_HYP  = 2'd2;

    localparam logic [BITWIDTH-1:0]       VAL_MAX    = {1'b0, {(BITWIDTH-1){1'b1}}};
    localparam logic [BITWIDTH-1:0]       VAL_MIN    = {1'b1, {(BITWIDTH-1){1'b0}}};
    localparam logic [SHIFT_BITWIDTH-1:0] LAST_STEP  = SHIFT_BITWIDTH'(ITERATIONS - 1);
    localparam logic [SHIFT_BITWIDTH-1:0] SHIFT_ONE  = SHIFT_BITWIDTH'(1);
    localparam logic [SHIFT_BITWIDTH-1:0] HYP_REP_LO = SHIFT_BITWIDTH'(4);
    localparam logic [SHIFT_BITWIDTH-1:0] HYP_REP_HI = SHIFT_BITWIDTH'(13);

    state_t                    state_q, state_d;
    logic [SHIFT_BITWIDTH-1:0] step_q, step_d;
    logic [SHIFT_BITWIDTH-1:0] shift_q, shift_d;
    logic                      rep_q, rep_d;
    logic                      mode_q, mode_d;
    logic [1:0]                coord_q, coord_d;
    logic [BITWIDTH-1:0]       x_q, x_d;
    logic [BITWIDTH-1:0]       y_q, y_d;
    logic [BITWIDTH-1:0]       z_q, z_d;

    logic                      dir_up;
    logic                      hyp_repeat;
    logic [BITWIDTH-1:0]       x_sh, y_sh;
    logic [BITWIDTH-1:0]       x_rot, y_rot, z_rot;

    // Arithmetic right shift; shift amounts past the word width leave only sign fill.
    function automatic logic [BITWIDTH-1:0] sra(
        input logic [BITWIDTH-1:0]       v,
        input logic [SHIFT_BITWIDTH-1:0] s
    );
        if (int'(s) >= BITWIDTH) begin
            sra = {BITWIDTH{v[BITWIDTH-1]}};
        end else begin
            sra = $signed(v) >>> s;
        end
    endfunction

    function automatic logic [BITWIDTH-1:0] sat_addsub(
        input logic [BITWIDTH-1:0] a,
        input logic [BITWIDTH-1:0] b,
        input logic                sub
    );
        logic [BITWIDTH:0] ext_a;
        logic [BITWIDTH:0] ext_b;
        logic [BITWIDTH:0] sum;
        ext_a = {a[BITWIDTH-1], a};
        ext_b = {b[BITWIDTH-1], b};
        sum   = sub ? (ext_a - ext_b) : (ext_a + ext_b);
        if (sum[BITWIDTH] != sum[BITWIDTH-1]) begin
            sat_addsub = sum[BITWIDTH] ? VAL_MIN : VAL_MAX;
        end else begin
            sat_addsub = sum[BITWIDTH-1:0];
        end
    endfunction

    // Single micro-rotation on the registered state
    always_comb begin
        dir_up = mode_q ? y_q[BITWIDTH-1] : ~z_q[BITWIDTH-1];
        x_sh   = sra(x_q, shift_q);
        y_sh   = sra(y_q, shift_q);
        x_rot  = x_q;
        y_rot  = y_q;
        z_rot  = z_q;
        if (coord_q != 2'd3) begin
            y_rot = sat_addsub(y_q, x_sh, ~dir_up);
            z_rot = sat_addsub(z_q, angle_i, dir_up);
            if (coord_q == COORD_CIRC) begin
                x_rot = sat_addsub(x_q, y_sh, dir_up);
            end else if (coord_q == COORD_HYP) begin
                x_rot = sat_addsub(x_q, y_sh, ~dir_up);
            end
        end
    end

    // Hyperbolic convergence needs shifts 4 and 13 run twice; rep_q marks the second pass.
    assign hyp_repeat = (coord_q == COORD_HYP) && !rep_q &&
                        ((shift_q == HYP_REP_LO) || (shift_q == HYP_REP_HI));

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        shift_d = shift_q;
        rep_d   = rep_q;
        mode_d  = mode_q;
        coord_d = coord_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    x_d     = X_i;
                    y_d     = Y_i;
                    z_d     = Z_i;
                    mode_d  = mode_i;
                    coord_d = coord_i;
                    step_d  = '0;
                    rep_d   = 1'b0;
                    shift_d = (coord_i == COORD_HYP) ? SHIFT_ONE : '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                x_d     = x_rot;
                y_d     = y_rot;
                z_d     = z_rot;
                step_d  = step_q + SHIFT_ONE;
                rep_d   = hyp_repeat;
                shift_d = hyp_repeat ? shift_q : (shift_q + SHIFT_ONE);
                if (step_q == LAST_STEP) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            shift_q <= '0;
            rep_q   <= 1'b0;
            mode_q  <= 1'b0;
            coord_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            shift_q <= shift_d;
            rep_q   <= rep_d;
            mode_q  <= mode_d;
            coord_q <= coord_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
        end
    end

    assign in_ready_o    = (state_q == S_IDLE);
    assign out_valid_o   = (state_q == S_DONE);
    assign busy_o        = (state_q == S_RUN) || (state_q == S_DONE);
    assign angle_idx_o   = shift_q;
    assign angle_coord_o = coord_q;
    assign X_o           = x_q;
    assign Y_o           = y_q;
    assign Z_o           = z_q;

endmodule
`default_nettype wire

// File: tb/tb_cordic_iter_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_iter_engine
// Purpose  : Directed, table-driven self-checking bench for cordic_iter_engine.
// Revision : 1.0
// ============================================================================
module tb_cordic_iter_engine;

    localparam int ITER = 12;

    typedef struct {
        logic       mode;
        logic [1:0] coord;
        int         x, y, z;
        int         ex, ey, ez;
        int         tol;
    } vec_t;

    logic       clk_i, rst_i;
    logic       in_valid_i, in_ready_o;
    logic       mode_i;
    logic [1:0] coord_i;
    logic [9:0] X_i, Y_i, Z_i;
    logic [3:0] angle_idx_o;
    logic [1:0] angle_coord_o;
    logic [9:0] angle_i;
    logic       out_valid_o, out_ready_i;
    logic [9:0] X_o, Y_o, Z_o;
    logic       busy_o;

    int   n_cmp = 0;
    int   n_err = 0;
    int   lat;
    int   res_x, res_y, res_z;
    int   idx_log [40];
    int   x_log   [40];
    int   y_log   [40];
    int   hyp_seq [12];
    vec_t vecs    [7];

    cordic_iter_engine dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .mode_i       (mode_i),
        .coord_i      (coord_i),
        .X_i          (X_i),
        .Y_i          (Y_i),
        .Z_i          (Z_i),
        .angle_idx_o  (angle_idx_o),
        .angle_coord_o(angle_coord_o),
        .angle_i      (angle_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .X_o          (X_o),
        .Y_o          (Y_o),
        .Z_o          (Z_o),
        .busy_o       (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Angle tables in Q1.9: atan(2^-i), 2^-i (1.0 clipped), atanh(2^-i)
    function automatic int tbl(input int coord, input int idx);
        int t;
        t = 0;
        case (coord)
            0: case (idx)
                0: t = 402; 1: t = 237; 2: t = 125; 3: t = 64; 4: t = 32;
                5: t = 16;  6: t = 8;   7: t = 4;   8: t = 2;  9: t = 1;
                default: t = 0;
            endcase
            1: case (idx)
                0: t = 511; 1: t = 256; 2: t = 128; 3: t = 64; 4: t = 32;
                5: t = 16;  6: t = 8;   7: t = 4;   8: t = 2;  9: t = 1;
                default: t = 0;
            endcase
            2: case (idx)
                1: t = 281; 2: t = 131; 3: t = 64; 4: t = 32; 5: t = 16;
                6: t = 8;   7: t = 4;   8: t = 2;  9: t = 1;
                default: t = 0;
            endcase
            default: t = 0;
        endcase
        return t;
    endfunction

    assign angle_i = 10'(tbl(int'(angle_coord_o), int'(angle_idx_o)));

    function automatic int sat(input int v);
        return (v > 511) ? 511 : ((v < -512) ? -512 : v);
    endfunction

    function automatic int ash(input int v, input int s);
        return (s >= 10) ? ((v < 0) ? -1 : 0) : (v >>> s);
    endfunction

    function automatic void model(input int mode, input int coord, input int x0, input int y0,
                                  input int z0, output int xr, output int yr, output int zr);
        int x, y, z, s, a, xs, ys, nx, ny, nz, n, j;
        int sched [ITER];
        bit up;
        n = 0;
        j = (coord == 2) ? 1 : 0;
        while (n < ITER) begin
            sched[n] = j;
            n++;
            if (coord == 2 && (j == 4 || j == 13) && n < ITER) begin
                sched[n] = j;
                n++;
            end
            j++;
        end
        x = x0; y = y0; z = z0;
        for (int k = 0; k < ITER; k++) begin
            s  = sched[k];
            a  = tbl(coord, s);
            up = mode ? (y < 0) : (z >= 0);
            xs = ash(x, s);
            ys = ash(y, s);
            nx = x; ny = y; nz = z;
            if (coord != 3) begin
                ny = sat(up ? y + xs : y - xs);
                nz = sat(up ? z - a : z + a);
                if (coord == 0) nx = sat(up ? x - ys : x + ys);
                else if (coord == 2) nx = sat(up ? x + ys : x - ys);
            end
            x = nx; y = ny; z = nz;
        end
        xr = x; yr = y; zr = z;
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic chk_tol(input string name, input int act, input int exp_v, input int tol);
        n_cmp++;
        if (act > exp_v + tol || act < exp_v - tol) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp_v, tol);
        end
    endtask

    task automatic run_op(input vec_t v, input int hold, input bit poke);
        int n, mx, my, mz;
        n = 0;
        @(negedge clk_i);
        while (!in_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        chk("in_ready_before_accept", int'(in_ready_o), 1);
        mode_i     = v.mode;
        coord_i    = v.coord;
        X_i        = 10'(v.x);
        Y_i        = 10'(v.y);
        Z_i        = 10'(v.z);
        in_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        X_i        = 10'h155;
        Y_i        = 10'h2aa;
        Z_i        = 10'h0f0;
        mode_i     = ~v.mode;
        coord_i    = v.coord ^ 2'd1;
        lat        = 0;
        while (1) begin
            @(negedge clk_i);
            if (out_valid_o || lat >= 40) break;
            idx_log[lat] = int'(angle_idx_o);
            x_log[lat]   = int'($signed(X_o));
            y_log[lat]   = int'($signed(Y_o));
            if (poke) begin
                if (lat == 3) begin
                    in_valid_i = 1'b1;
                    chk("in_ready_low_in_run", int'(in_ready_o), 0);
                end
                if (lat == 6) in_valid_i = 1'b0;
            end
            @(posedge clk_i);
            lat++;
        end
        chk("latency", lat, ITER);
        res_x = int'($signed(X_o));
        res_y = int'($signed(Y_o));
        res_z = int'($signed(Z_o));
        model(int'(v.mode), int'(v.coord), v.x, v.y, v.z, mx, my, mz);
        chk("model_x", res_x, mx);
        chk("model_y", res_y, my);
        chk("model_z", res_z, mz);
        chk_tol("table_x", res_x, v.ex, v.tol);
        chk_tol("table_y", res_y, v.ey, v.tol);
        chk_tol("table_z", res_z, v.ez, v.tol);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            chk("hold_valid", int'(out_valid_o), 1);
            chk("hold_x", int'($signed(X_o)), mx);
            chk("hold_y", int'($signed(Y_o)), my);
            chk("hold_z", int'($signed(Z_o)), mz);
        end
        out_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        out_ready_i = 1'b0;
        @(negedge clk_i);
        chk("exit_out_valid", int'(out_valid_o), 0);
        chk("exit_in_ready", int'(in_ready_o), 1);
        chk("exit_busy", int'(busy_o), 0);
    endtask

    initial begin
        // {mode, coord, X, Y, Z, expected X, Y, Z, tolerance}
        vecs[0] = '{1'b0, 2'd0, 311, 0, 268, 445, 257, -1, 2};
        // Z saturates at 511 on step 1 (402 + 237), so the angle settles well below pi/4
        vecs[1] = '{1'b1, 2'd0, 128, 128, 0, 300, 0, 273, 2};
        vecs[2] = '{1'b1, 2'd0, 200, 100, 0, 372, -1, 239, 2};
        vecs[3] = '{1'b0, 2'd1, 256, 0, 256, 256, 129, 0, 2};
        vecs[4] = '{1'b0, 2'd2, 256, 0, 128, 220, 54, -1, 2};
        vecs[5] = '{1'b1, 2'd3, 100, -50, 77, 100, -50, 77, 0};
        vecs[6] = '{1'b0, 2'd0, 511, -512, 0, 419, -419, -1, 2};
        hyp_seq = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11};

        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        mode_i      = 1'b0;
        coord_i     = 2'd0;
        X_i         = '0;
        Y_i         = '0;
        Z_i         = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_in_ready", int'(in_ready_o), 1);
        chk("rst_out_valid", int'(out_valid_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_x", int'(X_o), 0);
        chk("rst_y", int'(Y_o), 0);
        chk("rst_z", int'(Z_o), 0);
        chk("rst_idx", int'(angle_idx_o), 0);
        chk("rst_coord", int'(angle_coord_o), 0);
        rst_i = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i], (i == 1) ? 5 : 0, (i == 2));
            if (i == 0) begin
                for (int k = 0; k < ITER; k++) chk($sformatf("circ_idx[%0d]", k), idx_log[k], k);
            end
            if (i == 3) chk("lin_x_exact", res_x, 256);
            if (i == 4) begin
                for (int k = 0; k < ITER; k++)
                    chk($sformatf("hyp_idx[%0d]", k), idx_log[k], hyp_seq[k]);
            end
            if (i == 6) begin
                chk("sat_step0_x", x_log[1], 511);
                chk("sat_step0_y", y_log[1], -1);
                for (int k = 0; k < ITER; k++)
                    chk($sformatf("sat_x_nonneg[%0d]", k), int'(x_log[k] >= 0), 1);
            end
        end

        // Asynchronous reset in the middle of a hyperbolic operation
        @(negedge clk_i);
        mode_i     = 1'b0;
        coord_i    = 2'd2;
        X_i        = 10'd256;
        Y_i        = 10'd0;
        Z_i        = 10'd128;
        in_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        repeat (6) @(posedge clk_i);
        @(negedge clk_i);
        chk("pre_rst_busy", int'(busy_o), 1);
        chk("pre_rst_coord", int'(angle_coord_o), 2);
        chk("pre_rst_idx", int'(angle_idx_o), hyp_seq[6]);
        #2;
        rst_i = 1'b1;
        #1;
        chk("async_rst_busy", int'(busy_o), 0);
        chk("async_rst_in_ready", int'(in_ready_o), 1);
        chk("async_rst_out_valid", int'(out_valid_o), 0);
        chk("async_rst_x", int'(X_o), 0);
        chk("async_rst_y", int'(Y_o), 0);
        chk("async_rst_z", int'(Z_o), 0);
        chk("async_rst_idx", int'(angle_idx_o), 0);
        chk("async_rst_coord", int'(angle_coord_o), 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        run_op(vecs[0], 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
